// File: rtl/lstm_gate_if.sv
// lstm_gate_if: operand, weight and result bus between an LSTM gate
// and its feeder (x/y vectors, weight columns, bias, results).
interface lstm_gate_if #(
  parameter int INPUT_SZ  = 4,
  parameter int HIDDEN_SZ = 32,
  parameter int BITWIDTH  = 18
);
  localparam int XAW = $clog2(INPUT_SZ);
  localparam int YAW = $clog2(HIDDEN_SZ);
  localparam int VW  = BITWIDTH * HIDDEN_SZ;

  logic [BITWIDTH-1:0] inputVec;
  logic [BITWIDTH-1:0] prevOutVec;
  logic [VW-1:0]       weightMemOutput_X;
  logic [VW-1:0]       weightMemOutput_Y;
  logic [VW-1:0]       biasVec;
  logic                beginCalc;
  logic [XAW-1:0]      colAddressRead_X;
  logic [YAW-1:0]      colAddressRead_Y;
  logic                dataReady;
  logic [VW-1:0]       gateOutput;

  modport master (
    output inputVec, prevOutVec,
    output weightMemOutput_X, weightMemOutput_Y,
    output biasVec, beginCalc,
    input  colAddressRead_X, colAddressRead_Y,
    input  dataReady, gateOutput
  );

  modport slave (
    input  inputVec, prevOutVec,
    input  weightMemOutput_X, weightMemOutput_Y,
    input  biasVec, beginCalc,
    output colAddressRead_X, colAddressRead_Y,
    output dataReady, gateOutput
  );
endinterface

// File: rtl/lstm_gate.sv
// lstm_gate: sigmoid(Wx*x + Wy*y + b), one weight column per cycle,
// saturated sum fed through a shift-and-add piecewise-linear sigmoid.
module lstm_gate #(
  parameter int INPUT_SZ      = 4,
  parameter int HIDDEN_SZ     = 32,
  parameter int QN            = 6,
  parameter int QM            = 11,
  parameter int DSP48_PER_ROW = 2
) (
  input logic        clock,
  input logic        reset,
  lstm_gate_if.slave gate
);
  localparam int BW  = QN + QM + 1;
  localparam int XAW = $clog2(INPUT_SZ);
  localparam int YAW = $clog2(HIDDEN_SZ);
  // wide enough for HIDDEN_SZ worst-case shifted products
  localparam int AW  = 2 * BW - QM + YAW + 1;
  localparam int SW  = AW + 2;

  localparam logic signed [SW-1:0] SatHi =
    (SW'(1) <<< (BW - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SatLo = ~SatHi;

  localparam logic [BW-1:0] One  = BW'(1) << QM;
  localparam logic [BW-1:0] Five = BW'(5) << QM;
  localparam logic [BW-1:0] Knee = BW'(19) << (QM - 3);
  localparam logic [BW-1:0] Off2 = BW'(27) << (QM - 5);
  localparam logic [BW-1:0] Off1 = BW'(5) << (QM - 3);
  localparam logic [BW-1:0] Half = BW'(1) << (QM - 1);

  if (DSP48_PER_ROW < 1 || INPUT_SZ > HIDDEN_SZ) begin : gBadCfg
    $error("lstm_gate: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    IDLE, CALC, SUM, ACT, DONE
  } state_t;

  state_t state, nextState;

  logic signed [AW-1:0]   accX   [HIDDEN_SZ];
  logic signed [AW-1:0]   accY   [HIDDEN_SZ];
  logic signed [BW-1:0]   sumSat [HIDDEN_SZ];
  logic signed [2*BW-1:0] mulX   [HIDDEN_SZ];
  logic signed [2*BW-1:0] mulY   [HIDDEN_SZ];

  logic lastCol, xLive, xEnd, start;

  assign lastCol = gate.colAddressRead_Y == YAW'(HIDDEN_SZ - 1);
  assign xLive   = int'(gate.colAddressRead_Y) < INPUT_SZ;
  assign xEnd    = gate.colAddressRead_X == XAW'(INPUT_SZ - 1);
  assign start   = (state == IDLE || state == DONE) && gate.beginCalc;

  function automatic logic signed [BW-1:0] saturate(
    input logic signed [SW-1:0] v
  );
    if (v > SatHi) return SatHi[BW-1:0];
    if (v < SatLo) return SatLo[BW-1:0];
    return v[BW-1:0];
  endfunction

  // odd symmetry: negative inputs mirror around 0.5
  function automatic logic [BW-1:0] plan(
    input logic signed [BW-1:0] s
  );
    logic [BW-1:0] a, v;
    a = s[BW-1] ? -s : s;
    v = '0;
    unique case (1'b1)
      (a >= Five):              v = One;
      (a >= Knee && a < Five):  v = (a >> 5) + Off2;
      (a >= One && a < Knee):   v = (a >> 3) + Off1;
      default:                  v = (a >> 2) + Half;
    endcase
    return s[BW-1] ? One - v : v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, DONE: if (gate.beginCalc) nextState = CALC;
      CALC:       if (lastCol) nextState = SUM;
      SUM:        nextState = ACT;
      ACT:        nextState = DONE;
      default:    nextState = IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < HIDDEN_SZ; r++) begin
      mulX[r] = $signed(gate.weightMemOutput_X[r*BW +: BW])
              * $signed(gate.inputVec);
      mulY[r] = $signed(gate.weightMemOutput_Y[r*BW +: BW])
              * $signed(gate.prevOutVec);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < HIDDEN_SZ; r++) begin
        accX[r]   <= '0;
        accY[r]   <= '0;
        sumSat[r] <= '0;
      end
      gate.gateOutput       <= '0;
      gate.colAddressRead_X <= '0;
      gate.colAddressRead_Y <= '0;
      gate.dataReady        <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int r = 0; r < HIDDEN_SZ; r++) begin
              accX[r] <= '0;
              accY[r] <= '0;
            end
          end
          gate.dataReady <= (state == DONE) && !gate.beginCalc;
        end
        CALC: begin
          for (int r = 0; r < HIDDEN_SZ; r++) begin
            accY[r] <= accY[r] + AW'(mulY[r] >>> QM);
            if (xLive) accX[r] <= accX[r] + AW'(mulX[r] >>> QM);
          end
          gate.colAddressRead_Y <= lastCol ? '0
            : gate.colAddressRead_Y + YAW'(1);
          gate.colAddressRead_X <= lastCol ? '0
            : xEnd ? gate.colAddressRead_X
            : gate.colAddressRead_X + XAW'(1);
        end
        SUM: begin
          for (int r = 0; r < HIDDEN_SZ; r++)
            sumSat[r] <= saturate(SW'(accX[r]) + SW'(accY[r])
              + SW'($signed(gate.biasVec[r*BW +: BW])));
        end
        ACT: begin
          for (int r = 0; r < HIDDEN_SZ; r++)
            gate.gateOutput[r*BW +: BW] <= plan(sumSat[r]);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_gate.sv
// tb_lstm_gate: directed and random runs of lstm_gate compared with
// a whole-vector arithmetic reference of the gate equation.
module tb_lstm_gate;
  localparam int IN  = 4;
  localparam int HID = 32;
  localparam int QM  = 11;
  localparam int BW  = 18;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lstm_gate_if #(
    .INPUT_SZ(IN), .HIDDEN_SZ(HID), .BITWIDTH(BW)
  ) bus ();

  lstm_gate #(
    .INPUT_SZ(IN), .HIDDEN_SZ(HID), .QN(6), .QM(QM),
    .DSP48_PER_ROW(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .gate(bus.slave)
  );

  int wx[HID][IN];
  int wy[HID][HID];
  int xv[IN];
  int yv[HID];
  int bias[HID];
  int vectors = 0;
  int miscompares = 0;

  // feeder plus weight memories: combinational reads at the gate's addresses
  always_comb begin
    bus.inputVec   = BW'(xv[bus.colAddressRead_X]);
    bus.prevOutVec = BW'(yv[bus.colAddressRead_Y]);
    for (int r = 0; r < HID; r++) begin
      bus.weightMemOutput_X[r*BW +: BW] = BW'(wx[r][bus.colAddressRead_X]);
      bus.weightMemOutput_Y[r*BW +: BW] = BW'(wy[r][bus.colAddressRead_Y]);
      bus.biasVec[r*BW +: BW]           = BW'(bias[r]);
    end
  end

  task automatic checkVal(string tag, longint got, longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int q(real v);
    return int'(v * 2048.0);
  endfunction

  function automatic int refGate(int r);
    longint s, a;
    int v;
    s = bias[r];
    for (int k = 0; k < IN; k++)
      s += (longint'(wx[r][k]) * xv[k]) >>> QM;
    for (int k = 0; k < HID; k++)
      s += (longint'(wy[r][k]) * yv[k]) >>> QM;
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
    a = (s < 0) ? -s : s;
    if (a >= q(5.0))        v = q(1.0);
    else if (a >= q(2.375)) v = int'(a / 32) + q(0.84375);
    else if (a >= q(1.0))   v = int'(a / 8) + q(0.625);
    else                    v = int'(a / 4) + q(0.5);
    return (s < 0) ? q(1.0) - v : v;
  endfunction

  task automatic loadConst(int wxc, int xc, int wyc, int yc, int bc);
    for (int r = 0; r < HID; r++) begin
      for (int k = 0; k < IN; k++) wx[r][k] = wxc;
      for (int k = 0; k < HID; k++) wy[r][k] = wyc;
      bias[r] = bc;
    end
    for (int k = 0; k < IN; k++) xv[k] = xc;
    for (int k = 0; k < HID; k++) yv[k] = yc;
  endtask

  function automatic int rnd(int span);
    return int'($urandom_range(2 * span)) - span;
  endfunction

  task automatic loadRandom();
    for (int r = 0; r < HID; r++) begin
      for (int k = 0; k < IN; k++) wx[r][k] = rnd(3000);
      for (int k = 0; k < HID; k++) wy[r][k] = rnd(3000);
      bias[r] = rnd(6000);
    end
    for (int k = 0; k < IN; k++) xv[k] = rnd(3000);
    for (int k = 0; k < HID; k++) yv[k] = rnd(3000);
  endtask

  task automatic runCase(string tag, int hold = 1);
    int cnt;
    bus.beginCalc = 1'b1;
    @(negedge clock);
    cnt = 0;
    if (hold <= 1) bus.beginCalc = 1'b0;
    while (!bus.dataReady && cnt < 100) begin
      if (cnt < HID) begin
        checkVal({tag, ":addrY"}, bus.colAddressRead_Y, cnt);
        checkVal({tag, ":addrX"}, bus.colAddressRead_X,
                 (cnt < IN) ? cnt : IN - 1);
      end
      @(negedge clock);
      cnt++;
      if (cnt >= hold - 1) bus.beginCalc = 1'b0;
    end
    checkVal({tag, ":latency"}, cnt, HID + 3);
    for (int r = 0; r < HID; r++)
      checkVal($sformatf("%s:row%0d", tag, r),
               bus.gateOutput[r*BW +: BW], refGate(r));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.beginCalc = 1'b0;
    loadConst(0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    checkVal("rst:ready", bus.dataReady, 0);
    checkVal("rst:out", bus.gateOutput, 0);
    checkVal("rst:addrX", bus.colAddressRead_X, 0);
    checkVal("rst:addrY", bus.colAddressRead_Y, 0);
    reset = 1'b0;
    @(negedge clock);

    runCase("zero");
    checkVal("zero:half", bus.gateOutput[BW-1:0], 1024);
    loadConst(2048, 2048, 0, 0, 0);
    runCase("pos");
    checkVal("pos:val", bus.gateOutput[BW-1:0], 1984);
    loadConst(2048, -2048, 0, 0, 0);
    runCase("neg");
    checkVal("neg:val", bus.gateOutput[BW-1:0], 64);
    loadConst(0, 0, 0, 0, -1024);
    runCase("biasneg");
    checkVal("biasneg:val", bus.gateOutput[BW-1:0], 768);
    loadConst(0, 0, 31 * 2048, 31 * 2048, 0);
    runCase("sat");
    checkVal("sat:val", bus.gateOutput[BW-1:0], 2048);

    loadConst(0, 0, 0, 0, 0);
    for (int r = 0; r < HID; r++) bias[r] = r * 512;
    runCase("rowpos");
    for (int r = 0; r < HID; r++) bias[r] = -r * 512;
    runCase("rowneg");

    for (int i = 0; i < 3; i++) begin
      loadRandom();
      runCase($sformatf("rand%0d", i));
    end
    loadRandom();
    runCase("held", 3);

    bus.beginCalc = 1'b1;
    @(negedge clock);
    bus.beginCalc = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkVal("midrst:ready", bus.dataReady, 0);
    checkVal("midrst:out", bus.gateOutput, 0);
    checkVal("midrst:addrX", bus.colAddressRead_X, 0);
    checkVal("midrst:addrY", bus.colAddressRead_Y, 0);
    reset = 1'b0;
    @(negedge clock);
    loadRandom();
    runCase("afterrst");
    loadRandom();
    runCase("redo");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
